regfile_operand_fetch: RTL
==========================

Name: regfile_operand_fetch

Overview:
- Read-side client of the 32-entry register file, placed in the decode stage.
- Regfile read ports are registered: an address sampled at edge N returns data after edge N. A read and a write to the same address at the same edge returns the old value.
- This block issues rs1/rs2 addresses, collects the data one cycle later and forwards pending writeback values into it. It delivers a complete operand pair to execute under a valid/ready handshake and keeps held operands coherent while stalled.

Parameters:
- XLEN, 32, operand and writeback data width.
- TAG_W, 32, width of the opaque payload (PC, decoded control) carried alongside the operands.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  block accepts a request this cycle.
- in_rs1  input  5  source register 1 index.
- in_rs2  input  5  source register 2 index.
- in_tag  input  TAG_W  payload, passed through unchanged.
- rf_read_addr1  output  5  to regfile read port 1.
- rf_read_addr2  output  5  to regfile read port 2.
- rf_read_data1  input  XLEN  from regfile, valid one cycle after its address.
- rf_read_data2  input  XLEN  from regfile, valid one cycle after its address.
- wb_en  input  1  snoop of the regfile write enable.
- wb_addr  input  5  snoop of the regfile write address.
- wb_data  input  XLEN  snoop of the regfile write data.
- out_valid  output  1  operand pair valid.
- out_ready  input  1  downstream accepts.
- out_rs1_data  output  XLEN  operand 1.
- out_rs2_data  output  XLEN  operand 2.
- out_tag  output  TAG_W  payload of the presented request.

Behaviour:
- Reset and interface basics:
  - Clock is clk; reset is rst, synchronous and active-high.
  - On reset: state EMPTY, out_valid=0, out_tag=0, all hold and bypass registers=0. Reset mid-operation drops any in-flight request silently.
  - rf_read_addr1/2 = in_rs1/in_rs2, combinational at all times.
  - Accept = in_valid && in_ready.
- States:
  - EMPTY: out_valid=0; in_ready=1.
  - FETCH: out_valid=1; data comes from the regfile this cycle; in_ready=out_ready.
  - HOLD: out_valid=1; data comes from hold registers; in_ready=out_ready.
- Transitions:
  - EMPTY: accept -> FETCH, else stay.
  - FETCH/HOLD with out_ready: accept -> FETCH, else -> EMPTY.
  - FETCH without out_ready -> HOLD, capturing the presented operands into hold registers.
  - HOLD without out_ready -> HOLD.
- On accept:
  - Latch rs1, rs2 and tag.
  - Capture bypass: if wb_en && wb_addr==rsN && rsN!=0 this cycle, set bypN=1 and bypN_data=wb_data. This covers the write the regfile hides at the same edge.
- Operand select per N, in priority order:
  1. rsN==0 -> 0. Regfile x0 is not reset-initialised, so rf data is never used for x0.
  2. wb_en && wb_addr==rsN -> wb_data (combinational forward of the older in-flight write).
  3. FETCH: bypN ? bypN_data : rf_read_dataN; HOLD: holdN.
- In HOLD, every matching wb write (rsN!=0) updates holdN at the edge.
- Latency: accept at edge N -> out_valid after edge N. Throughput one per cycle with out_ready held high.
- Both operands matching the same wb_addr are both forwarded.
- wb_addr==0 is never forwarded.

Decomposition:
- Package regfile_pkg: state enum {EMPTY, FETCH, HOLD}, REG_IDX_W=5, REG_ZERO=5'd0.
- Sub-module operand_bypass, instantiated twice (rs1, rs2). It holds the priority select and the hold/bypass register update for one operand.

Test Plan:
- Reset: regfile x5=0x1234. Accept rs1=5, rs2=0 -> next cycle out_valid=1, out_rs1_data=0x1234, out_rs2_data=0, out_tag echoed.
- Same-edge hazard: accept rs1=7 while wb_en=1, wb_addr=7, wb_data=0xAAAA (regfile returns old 0x1) -> out_rs1_data=0xAAAA.
- Forward at output: in FETCH with wb_en=1, wb_addr=3, wb_data=0x55, rs2=3 -> out_rs2_data=0x55 combinationally that cycle.
- Stall coherence: out_ready=0 for 3 cycles, write x9=0xBEEF during cycle 2, rs1=9 -> out_rs1_data=0xBEEF from cycle 2 onward. On release, in_ready=1 and the next request is accepted.
- Back-to-back: 4 requests with in_valid and out_ready high -> 4 consecutive out_valid cycles, tags in order, no bubbles. Also check wb_addr=0 with wb_data=0xFF and rs1=0 -> operand 0.
- Reset mid-HOLD: assert rst -> out_valid=0 next cycle, in_ready=1, no stale output afterward.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file operand fetch path.
package regfile_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // EMPTY: nothing presented. FETCH: operands come straight from the regfile
  // read ports. HOLD: operands come from the local hold registers (stalled).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/operand_bypass.sv
// One operand lane: latched source index, same-edge bypass capture,
// hold register for stalls and the priority select onto the operand bus.
module operand_bypass
  import regfile_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic [REG_IDX_W-1:0] rs_idx,
  input  logic                 in_fetch,
  input  logic                 in_hold,
  input  logic                 capture_hold,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [XLEN-1:0]      rf_data,
  output logic [XLEN-1:0]      operand
);

  logic [REG_IDX_W-1:0] rs_reg;
  logic                 byp_reg;
  logic [XLEN-1:0]      byp_data_reg;
  logic [XLEN-1:0]      hold_reg;
  logic                 wb_hit_new;
  logic                 wb_hit_cur;

  // Write hitting the incoming request: the regfile returns the old value for
  // this one, so it must be captured locally at the accept edge.
  assign wb_hit_new = wb_en && (wb_addr == rs_idx) && (rs_idx != REG_ZERO);
  // Write hitting the presented request: forwarded combinationally.
  assign wb_hit_cur = wb_en && (wb_addr == rs_reg) && (rs_reg != REG_ZERO);

  // Operand priority: x0, in-flight write, then regfile/bypass or hold copy.
  always_comb begin
    operand = '0;
    if (rs_reg == REG_ZERO) begin
      operand = '0;
    end else if (wb_hit_cur) begin
      operand = wb_data;
    end else if (in_fetch) begin
      operand = byp_reg ? byp_data_reg : rf_data;
    end else begin
      operand = hold_reg;
    end
  end

  // Latch index/bypass on accept; keep the hold copy coherent while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_reg       <= REG_ZERO;
      byp_reg      <= 1'b0;
      byp_data_reg <= '0;
      hold_reg     <= '0;
    end else begin
      if (accept) begin
        rs_reg       <= rs_idx;
        byp_reg      <= wb_hit_new;
        byp_data_reg <= wb_hit_new ? wb_data : '0;
      end
      if (capture_hold) begin
        hold_reg <= operand;
      end else if (in_hold && wb_hit_cur) begin
        hold_reg <= wb_data;
      end
    end
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Decode-stage operand fetch: issues regfile read addresses, merges pending
// writebacks and presents an operand pair to execute under valid/ready.
module regfile_operand_fetch
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic [TAG_W-1:0]     in_tag,
  output logic [REG_IDX_W-1:0] rf_read_addr1,
  output logic [REG_IDX_W-1:0] rf_read_addr2,
  input  logic [XLEN-1:0]      rf_read_data1,
  input  logic [XLEN-1:0]      rf_read_data2,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output logic [TAG_W-1:0]     out_tag
);

  fetch_state_e         state_reg;
  fetch_state_e         state_next;
  logic [TAG_W-1:0]     tag_reg;
  logic                 accept;
  logic                 in_fetch;
  logic                 in_hold;
  logic                 capture_hold;

  logic [REG_IDX_W-1:0] rs_idx  [2];
  logic [XLEN-1:0]      rf_data [2];
  logic [XLEN-1:0]      operand [2];

  // Read addresses go straight to the regfile so data lands the cycle after accept.
  assign rf_read_addr1 = in_rs1;
  assign rf_read_addr2 = in_rs2;

  assign in_ready     = (state_reg == EMPTY) || out_ready;
  assign accept       = in_valid && in_ready;
  assign out_valid    = (state_reg != EMPTY);
  assign in_fetch     = (state_reg == FETCH);
  assign in_hold      = (state_reg == HOLD);
  assign capture_hold = in_fetch && !out_ready;
  assign out_tag      = tag_reg;

  assign rs_idx[0]    = in_rs1;
  assign rs_idx[1]    = in_rs2;
  assign rf_data[0]   = rf_read_data1;
  assign rf_data[1]   = rf_read_data2;
  assign out_rs1_data = operand[0];
  assign out_rs2_data = operand[1];

  // Next-state: FETCH whenever a new request lands, HOLD when the presented
  // pair is not taken, EMPTY when it drains with nothing behind it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) state_next = FETCH;
      end
      FETCH, HOLD: begin
        if (out_ready) state_next = accept ? FETCH : EMPTY;
        else           state_next = HOLD;
      end
      default: state_next = EMPTY;
    endcase
  end

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      tag_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) tag_reg <= in_tag;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      operand_bypass #(
        .XLEN(XLEN)
      ) u_lane (
        .clk          (clk),
        .rst          (rst),
        .accept       (accept),
        .rs_idx       (rs_idx[gi]),
        .in_fetch     (in_fetch),
        .in_hold      (in_hold),
        .capture_hold (capture_hold),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .rf_data      (rf_data[gi]),
        .operand      (operand[gi])
      );
    end
  endgenerate

endmodule
